pipeline_wb: RTL and testbench

PIPELINE_WB -- requirements
Module: pipeline_wb

---
 rtl/pipeline_wb_if.sv | 26 ++
 rtl/pipeline_wb.sv | 48 ++++
 tb/tb_pipeline_wb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_wb_if.sv
// rtl/pipeline_wb_if.sv - write-back stage bus: MEM/WB inputs, decode read ports, observed outputs
interface pipeline_wb_if;
    logic [7:0]  DM;
    logic [7:0]  ALU_ea;
    logic [1:0]  ra;
    logic        wb_wb_sel;
    logic        wb_data_sel;
    logic        wb_reg_en;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic [7:0]  wb_data;
    logic [7:0]  out_port;
    logic [15:0] retire_cnt;

    modport master (
        output DM, ALU_ea, ra, wb_wb_sel, wb_data_sel, wb_reg_en, rs1, rs2,
        input  rd1, rd2, wb_data, out_port, retire_cnt
    );

    modport slave (
        input  DM, ALU_ea, ra, wb_wb_sel, wb_data_sel, wb_reg_en, rs1, rs2,
        output rd1, rd2, wb_data, out_port, retire_cnt
    );
endinterface

// File: rtl/pipeline_wb.sv
// rtl/pipeline_wb.sv - write-back stage: 4x8 register file, output port, saturating retire counter
// Define WB_BYPASS_EN to forward the in-flight register write onto rd1/rd2.
module pipeline_wb (
    input  logic          clk,
    input  logic          rst,
    pipeline_wb_if.slave  bus
);
    logic [7:0]  regs [0:3];
    logic [7:0]  out_port_q;
    logic [15:0] retire_q;
    logic [7:0]  wb_data;

    assign wb_data = bus.wb_data_sel ? bus.DM : bus.ALU_ea;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            out_port_q <= 8'h00;
            retire_q   <= 16'h0000;
        end else if (bus.wb_reg_en) begin
            if (bus.wb_wb_sel) begin
                regs[bus.ra] <= wb_data;
            end else begin
                out_port_q <= wb_data;
            end
            // Counter sticks at all-ones rather than wrapping.
            if (retire_q != 16'hFFFF) begin
                retire_q <= retire_q + 16'h0001;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic reg_wr;
    assign reg_wr  = rst && bus.wb_reg_en && bus.wb_wb_sel;
    assign bus.rd1 = (reg_wr && (bus.ra == bus.rs1)) ? wb_data : regs[bus.rs1];
    assign bus.rd2 = (reg_wr && (bus.ra == bus.rs2)) ? wb_data : regs[bus.rs2];
`else
    assign bus.rd1 = regs[bus.rs1];
    assign bus.rd2 = regs[bus.rs2];
`endif

    assign bus.wb_data    = wb_data;
    assign bus.out_port   = out_port_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_pipeline_wb.sv
// tb/tb_pipeline_wb.sv - scoreboard bench for pipeline_wb (both WB_BYPASS_EN builds)
module tb_pipeline_wb;
    localparam int S_RD1 = 0, S_RD2 = 1, S_WBD = 2, S_OUT = 3, S_CNT = 4;

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    pipeline_wb_if bus ();

    pipeline_wb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    function automatic logic [15:0] sample(int sig);
        case (sig)
            S_RD1:   return {8'h00, bus.rd1};
            S_RD2:   return {8'h00, bus.rd2};
            S_WBD:   return {8'h00, bus.wb_data};
            S_OUT:   return {8'h00, bus.out_port};
            default: return bus.retire_cnt;
        endcase
    endfunction

    // Monitor: drains expectations mid-cycle, away from the active edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            act = sample(e.sig);
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(string name, int sig, logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic en, logic wsel, logic dsel, logic [1:0] a,
                         logic [7:0] dm, logic [7:0] alu);
        bus.wb_reg_en   = en;
        bus.wb_wb_sel   = wsel;
        bus.wb_data_sel = dsel;
        bus.ra          = a;
        bus.DM          = dm;
        bus.ALU_ea      = alu;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        bus.rs1 = 2'd0;
        bus.rs2 = 2'd0;
        step();
        expect_val("reset_rd1", S_RD1, 16'h0000);
        expect_val("reset_out", S_OUT, 16'h0000);
        expect_val("reset_cnt", S_CNT, 16'h0000);

        // Reset with a simultaneous write pending
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 8'h55);
        step();
        drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h55);
        bus.rs1 = 2'd2;
        expect_val("preload_r2", S_RD1, 16'h0055);
        expect_val("preload_cnt", S_CNT, 16'h0001);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 8'h77);
        expect_val("no_bypass_in_reset", S_RD1, 16'h0055);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h77);
        bus.rs1 = 2'd0;
        bus.rs2 = 2'd1;
        expect_val("rst_r0", S_RD1, 16'h0000);
        expect_val("rst_r1", S_RD2, 16'h0000);
        expect_val("rst_out", S_OUT, 16'h0000);
        expect_val("rst_cnt", S_CNT, 16'h0000);
        step();
        bus.rs1 = 2'd2;
        bus.rs2 = 2'd3;
        expect_val("rst_r2", S_RD1, 16'h0000);
        expect_val("rst_r3", S_RD2, 16'h0000);

        // Source mux: DM then ALU_ea into R2
        step();
        drive(1'b1, 1'b1, 1'b1, 2'd2, 8'hA5, 8'h3C);
        expect_val("mux_wbd_dm", S_WBD, 16'h00A5);
`ifdef WB_BYPASS_EN
        expect_val("mux_rd1_c0", S_RD1, 16'h00A5);
`else
        expect_val("mux_rd1_c0", S_RD1, 16'h0000);
`endif
        step();
        bus.wb_data_sel = 1'b0;
        expect_val("mux_wbd_alu", S_WBD, 16'h003C);
`ifdef WB_BYPASS_EN
        expect_val("mux_rd1_c1", S_RD1, 16'h003C);
`else
        expect_val("mux_rd1_c1", S_RD1, 16'h00A5);
`endif
        step();
        bus.wb_reg_en = 1'b0;
        expect_val("mux_rd1_c2", S_RD1, 16'h003C);
        expect_val("mux_cnt", S_CNT, 16'h0002);

        // Output-port write; R2 is also ra so bypass must stay off
        step();
        drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h11, 8'h7E);
        bus.rs2 = 2'd0;
        expect_val("port_wbd", S_WBD, 16'h007E);
        expect_val("port_rd1_nobyp", S_RD1, 16'h003C);
        step();
        bus.wb_reg_en = 1'b0;
        expect_val("port_out", S_OUT, 16'h007E);
        expect_val("port_r2_kept", S_RD1, 16'h003C);
        expect_val("port_r0_kept", S_RD2, 16'h0000);
        expect_val("port_cnt", S_CNT, 16'h0003);

        // Same-cycle read/write on R1
        step();
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 8'h10);
        step();
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 8'h99);
        bus.rs1 = 2'd1;
        bus.rs2 = 2'd1;
`ifdef WB_BYPASS_EN
        expect_val("rw_rd1", S_RD1, 16'h0099);
        expect_val("rw_rd2", S_RD2, 16'h0099);
`else
        expect_val("rw_rd1", S_RD1, 16'h0010);
        expect_val("rw_rd2", S_RD2, 16'h0010);
`endif
        step();
        bus.wb_reg_en = 1'b0;
        expect_val("rw_rd1_after", S_RD1, 16'h0099);
        expect_val("rw_rd2_after", S_RD2, 16'h0099);
        expect_val("rw_cnt", S_CNT, 16'h0005);

        // Disabled write into R3
        step();
        drive(1'b0, 1'b1, 1'b1, 2'd3, 8'hFF, 8'h00);
        bus.rs1 = 2'd3;
        expect_val("dis_wbd", S_WBD, 16'h00FF);
        expect_val("dis_rd1_nobyp", S_RD1, 16'h0000);
        step();
        expect_val("dis_r3", S_RD1, 16'h0000);
        expect_val("dis_out", S_OUT, 16'h007E);
        expect_val("dis_cnt", S_CNT, 16'h0005);

        // Saturation of the retire counter
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        step();
        rst = 1'b1;
        expect_val("sat_start", S_CNT, 16'h0000);
        bus.wb_reg_en = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        expect_val("sat_fffe", S_CNT, 16'hFFFE);
        step();
        expect_val("sat_ffff_1", S_CNT, 16'hFFFF);
        step();
        expect_val("sat_ffff_2", S_CNT, 16'hFFFF);
        step();
        expect_val("sat_ffff_3", S_CNT, 16'hFFFF);
        bus.wb_reg_en = 1'b0;
        step();

        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
